// File: rtl/usrt_pkg.sv
// Shared definitions for the USRT register controller.
//   - register select codes used by the read-data mux
//   - status register bit positions
//   - TX write FSM state type
//   - default character width
package usrt_pkg;

  localparam int unsigned DataWDefault = 8;

  localparam logic [1:0] SelSt   = 2'b00;
  localparam logic [1:0] SelTx   = 2'b01;
  localparam logic [1:0] SelRx   = 2'b10;
  localparam logic [1:0] SelNone = 2'b11;

  localparam int unsigned BitTxEmpty  = 0;
  localparam int unsigned BitTxFull   = 1;
  localparam int unsigned BitRxValid  = 2;
  localparam int unsigned BitOverrun  = 3;
  localparam int unsigned BitTxDrop   = 4;
  localparam int unsigned BitTxBusy   = 5;
  localparam int unsigned BitIrqEnRx  = 8;
  localparam int unsigned BitIrqEnTxe = 9;
  localparam int unsigned BitIrqEnErr = 10;
  localparam int unsigned BitCountLo  = 12;

  typedef enum logic [0:0] {StIdle, StWait} tx_state_e;

endpackage

// File: rtl/usrt_txfifo.sv
// TX FIFO between the APB write path and the TX shifter.
//   clk_i/rst_ni   clock, async active-low reset
//   push_i/data_i  write one entry (caller guarantees room or a same-cycle pop)
//   pop_i          drop the head entry
//   data_o         head entry
//   full_o/empty_o occupancy flags
//   count_o        number of stored entries
module usrt_txfifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned DataW = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [DataW-1:0]         data_i,
  input  logic                     pop_i,
  output logic [DataW-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int unsigned AddrW  = $clog2(Depth);
  localparam int unsigned CountW = AddrW + 1;

  logic [DataW-1:0]  mem_q [Depth];
  logic [AddrW-1:0]  wptr_q, rptr_q;
  logic [CountW-1:0] count_q, count_d;

  // Depth is a power of two, so pointers wrap by natural overflow.
  always_comb begin
    count_d = count_q;
    unique case ({push_i, pop_i})
      2'b10:   count_d = count_q + CountW'(1);
      2'b01:   count_d = count_q - CountW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + AddrW'(1);
      if (pop_i)  rptr_q <= rptr_q + AddrW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wptr_q] <= data_i;
  end

  assign data_o  = mem_q[rptr_q];
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CountW'(Depth));
  assign count_o = count_q;

endmodule

// File: rtl/usrt_regctl.sv
// APB-side register controller for the USRT peripheral.
//   i_Clk/i_Rst_n        clock, async active-low reset
//   i_Stw_En/i_Str_En    status write / read strobes
//   i_Tx_En/i_Rx_En      TX data write / RX data read strobes
//   i_Pwdata, o_Prdata   APB write / read data
//   o_Pready, o_Pslverr  APB completion (wait states while TX FIFO full)
//   o_Tx_*, i_Tx_*       TX FIFO head handshake with the TX shifter
//   i_Rx_Data/i_Rx_Valid character from the RX shifter
//   o_Irq                registered level interrupt
module usrt_regctl
  import usrt_pkg::*;
#(
  parameter int unsigned DATA_W   = DataWDefault,
  parameter int unsigned TX_DEPTH = 4,
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic              i_Clk,
  input  logic              i_Rst_n,
  input  logic              i_Stw_En,
  input  logic              i_Str_En,
  input  logic              i_Tx_En,
  input  logic              i_Rx_En,
  input  logic [31:0]       i_Pwdata,
  output logic [31:0]       o_Prdata,
  output logic              o_Pready,
  output logic              o_Pslverr,
  output logic [DATA_W-1:0] o_Tx_Data,
  output logic              o_Tx_Valid,
  input  logic              i_Tx_Ready,
  input  logic              i_Tx_Busy,
  input  logic [DATA_W-1:0] i_Rx_Data,
  input  logic              i_Rx_Valid,
  output logic              o_Irq
);

  localparam int unsigned CntW = $clog2(WAIT_MAX + 1);

  tx_state_e                 state_q, state_d;
  logic [CntW-1:0]           cnt_q, cnt_d;
  logic                      push, pop, push_ok, drop_set;
  logic                      fifo_full, fifo_empty;
  logic [$clog2(TX_DEPTH):0] fifo_count;

  logic [DATA_W-1:0] rx_data_q;
  logic              rx_valid_q, overrun_q, overrun_d, drop_q, drop_d;
  logic              en_rx_q, en_txe_q, en_err_q, irq_d, irq_q;
  logic              tx_empty_idle;
  logic [31:0]       status;
  logic [1:0]        sel;
  logic              unused_pwdata;

  assign unused_pwdata = ^i_Pwdata;

  assign pop     = !fifo_empty && i_Tx_Ready;
  assign push_ok = !fifo_full || pop;

  usrt_txfifo #(
    .Depth (TX_DEPTH),
    .DataW (DATA_W)
  ) u_txfifo (
    .clk_i   (i_Clk),
    .rst_ni  (i_Rst_n),
    .push_i  (push),
    .data_i  (i_Pwdata[DATA_W-1:0]),
    .pop_i   (pop),
    .data_o  (o_Tx_Data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign o_Tx_Valid = !fifo_empty;

  // TX write FSM: stalls the APB access while the FIFO is full.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    push      = 1'b0;
    drop_set  = 1'b0;
    o_Pready  = 1'b1;
    o_Pslverr = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (i_Tx_En) begin
          if (push_ok) begin
            push = 1'b1;
          end else begin
            o_Pready = 1'b0;
            cnt_d    = CntW'(1);
            state_d  = StWait;
          end
        end
      end
      StWait: begin
        if (!i_Tx_En) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else if (push_ok) begin
          push    = 1'b1;
          cnt_d   = '0;
          state_d = StIdle;
        end else if (cnt_q == CntW'(WAIT_MAX)) begin
          o_Pslverr = 1'b1;
          drop_set  = 1'b1;
          cnt_d     = '0;
          state_d   = StIdle;
        end else begin
          o_Pready = 1'b0;
          cnt_d    = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    status                            = '0;
    status[BitTxEmpty]                = fifo_empty;
    status[BitTxFull]                 = fifo_full;
    status[BitRxValid]                = rx_valid_q;
    status[BitOverrun]                = overrun_q;
    status[BitTxDrop]                 = drop_q;
    status[BitTxBusy]                 = i_Tx_Busy || !fifo_empty;
    status[BitIrqEnRx]                = en_rx_q;
    status[BitIrqEnTxe]               = en_txe_q;
    status[BitIrqEnErr]               = en_err_q;
    status[BitCountLo+3:BitCountLo]   = 4'(fifo_count);
  end

  always_comb begin
    if (i_Str_En)     sel = SelSt;
    else if (i_Tx_En) sel = SelTx;
    else if (i_Rx_En) sel = SelRx;
    else              sel = SelNone;
    o_Prdata = '0;
    unique case (sel)
      SelSt:   o_Prdata = status;
      SelRx:   o_Prdata = rx_valid_q ? 32'(rx_data_q) : '0;
      default: o_Prdata = '0;
    endcase
  end

  // A new event in the same cycle as a w1c clear wins, so it is not lost.
  always_comb begin
    overrun_d = overrun_q;
    drop_d    = drop_q;
    if (i_Stw_En && i_Pwdata[BitOverrun]) overrun_d = 1'b0;
    if (i_Stw_En && i_Pwdata[BitTxDrop])  drop_d    = 1'b0;
    if (i_Rx_Valid && rx_valid_q && !i_Rx_En) overrun_d = 1'b1;
    if (drop_set) drop_d = 1'b1;
  end

  assign tx_empty_idle = fifo_empty && !i_Tx_Busy;
  assign irq_d = (en_rx_q && rx_valid_q) || (en_txe_q && tx_empty_idle) ||
                 (en_err_q && (overrun_q || drop_q));

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
      drop_q     <= 1'b0;
      en_rx_q    <= 1'b0;
      en_txe_q   <= 1'b0;
      en_err_q   <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      overrun_q <= overrun_d;
      drop_q    <= drop_d;
      irq_q     <= irq_d;
      if (i_Stw_En) begin
        en_rx_q  <= i_Pwdata[BitIrqEnRx];
        en_txe_q <= i_Pwdata[BitIrqEnTxe];
        en_err_q <= i_Pwdata[BitIrqEnErr];
      end
      // A read in the same cycle frees the holding register for the new character.
      if (i_Rx_Valid && (!rx_valid_q || i_Rx_En)) begin
        rx_data_q  <= i_Rx_Data;
        rx_valid_q <= 1'b1;
      end else if (i_Rx_En) begin
        rx_valid_q <= 1'b0;
      end
    end
  end

  assign o_Irq = irq_q;

endmodule

// File: tb/tb_usrt_regctl.sv
module tb_usrt_regctl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stw_en, str_en, tx_en, rx_en;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready, pslverr;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready, tx_busy;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        irq;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  usrt_regctl #(
    .DATA_W   (8),
    .TX_DEPTH (4),
    .WAIT_MAX (15)
  ) dut (
    .i_Clk      (clk),
    .i_Rst_n    (rst_n),
    .i_Stw_En   (stw_en),
    .i_Str_En   (str_en),
    .i_Tx_En    (tx_en),
    .i_Rx_En    (rx_en),
    .i_Pwdata   (pwdata),
    .o_Prdata   (prdata),
    .o_Pready   (pready),
    .o_Pslverr  (pslverr),
    .o_Tx_Data  (tx_data),
    .o_Tx_Valid (tx_valid),
    .i_Tx_Ready (tx_ready),
    .i_Tx_Busy  (tx_busy),
    .i_Rx_Data  (rx_data),
    .i_Rx_Valid (rx_valid),
    .o_Irq      (irq)
  );

  // Advance one clock: from just after a negedge to just after the next.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stw_en = 0; str_en = 0; tx_en = 0; rx_en = 0; pwdata = '0;
    tx_ready = 0; tx_busy = 0; rx_data = '0; rx_valid = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #12;
    n_cmp++; if (pready !== 1'b1) begin n_err++; $display("FAIL rst_pready got %b want 1", pready); end
    n_cmp++; if (pslverr !== 1'b0) begin n_err++; $display("FAIL rst_pslverr got %b want 0", pslverr); end
    n_cmp++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL rst_txvalid got %b want 0", tx_valid); end
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL rst_irq got %b want 0", irq); end
    @(negedge clk); rst_n = 1'b1; #1;
    n_cmp++; if (prdata !== 32'h0) begin n_err++; $display("FAIL idle_prdata got %h want 0", prdata); end
    str_en = 1; #1;
    n_cmp++; if (prdata !== 32'h1) begin n_err++; $display("FAIL rst_status got %h want 00000001", prdata); end
    n_cmp++; if (pready !== 1'b1) begin n_err++; $display("FAIL rst_st_pready got %b want 1", pready); end
    tick(); str_en = 0;
  endtask

  task automatic fill_fifo(input logic [7:0] base);
    tx_en = 1;
    for (int i = 1; i <= 4; i++) begin
      pwdata = 32'(base * i); #1;
      n_cmp++; if (pready !== 1'b1) begin n_err++; $display("FAIL fill_pready[%0d] got %b want 1", i, pready); end
      tick();
    end
    tx_en = 0; pwdata = '0;
  endtask

  task automatic drain_check(input logic [7:0] e0, e1, e2, e3);
    logic [7:0] exp_q [4];
    exp_q = '{e0, e1, e2, e3};
    tx_ready = 1; #1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (tx_valid !== 1'b1 || tx_data !== exp_q[i]) begin
        n_err++; $display("FAIL drain[%0d] got v=%b d=%h want v=1 d=%h", i, tx_valid, tx_data, exp_q[i]);
      end
      tick();
    end
    n_cmp++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL drain_empty got %b want 0", tx_valid); end
    tx_ready = 0;
  endtask

  task automatic test_tx_fill();
    fill_fifo(8'h11);
    str_en = 1; #1;
    n_cmp++; if (prdata !== 32'h4022) begin n_err++; $display("FAIL full_status got %h want 00004022", prdata); end
    tick(); str_en = 0;
    drain_check(8'h11, 8'h22, 8'h33, 8'h44);
  endtask

  task automatic test_tx_wait();
    fill_fifo(8'h01);
    tx_en = 1; pwdata = 32'h55;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (pready !== 1'b0) begin n_err++; $display("FAIL wait_low[%0d] got %b want 0", i, pready); end
      tick();
    end
    tx_ready = 1; #1;
    n_cmp++;
    if (pready !== 1'b1 || pslverr !== 1'b0) begin
      n_err++; $display("FAIL wait_done got rdy=%b err=%b want rdy=1 err=0", pready, pslverr);
    end
    tick(); tx_en = 0; tx_ready = 0; pwdata = '0;
    drain_check(8'h02, 8'h03, 8'h04, 8'h55);
  endtask

  task automatic test_tx_drop();
    fill_fifo(8'h10);
    tx_en = 1; pwdata = 32'h66;
    for (int i = 0; i < 15; i++) begin
      #1;
      n_cmp++; if (pready !== 1'b0) begin n_err++; $display("FAIL drop_low[%0d] got %b want 0", i, pready); end
      tick();
    end
    n_cmp++;
    if (pready !== 1'b1 || pslverr !== 1'b1) begin
      n_err++; $display("FAIL drop_err got rdy=%b err=%b want rdy=1 err=1", pready, pslverr);
    end
    tick(); tx_en = 0; pwdata = '0;
    str_en = 1; #1;
    n_cmp++; if (prdata !== 32'h4032) begin n_err++; $display("FAIL drop_status got %h want 00004032", prdata); end
    tick(); str_en = 0;
    stw_en = 1; pwdata = 32'h10; tick(); stw_en = 0; pwdata = '0;
    str_en = 1; #1;
    n_cmp++; if (prdata !== 32'h4022) begin n_err++; $display("FAIL drop_clear got %h want 00004022", prdata); end
    tick(); str_en = 0;
    drain_check(8'h10, 8'h20, 8'h30, 8'h40);
  endtask

  task automatic test_rx();
    rx_valid = 1; rx_data = 8'hA5; tick();
    rx_data = 8'h5A; tick();
    rx_valid = 0; rx_en = 1; #1;
    n_cmp++; if (prdata !== 32'hA5) begin n_err++; $display("FAIL rx_first got %h want 000000a5", prdata); end
    tick(); rx_en = 0;
    str_en = 1; #1;
    n_cmp++; if (prdata !== 32'h9) begin n_err++; $display("FAIL rx_overrun got %h want 00000009", prdata); end
    tick(); str_en = 0;
    rx_valid = 1; rx_data = 8'hA5; tick();
    rx_data = 8'h3C; rx_en = 1; #1;
    n_cmp++; if (prdata !== 32'hA5) begin n_err++; $display("FAIL rx_same got %h want 000000a5", prdata); end
    tick(); rx_valid = 0; rx_en = 0;
    str_en = 1; #1;
    n_cmp++; if (prdata !== 32'hD) begin n_err++; $display("FAIL rx_still_valid got %h want 0000000d", prdata); end
    tick(); str_en = 0;
    rx_en = 1; #1;
    n_cmp++; if (prdata !== 32'h3C) begin n_err++; $display("FAIL rx_second got %h want 0000003c", prdata); end
    tick(); #1;
    n_cmp++; if (prdata !== 32'h0) begin n_err++; $display("FAIL rx_empty got %h want 0", prdata); end
    tick(); rx_en = 0;
    stw_en = 1; pwdata = 32'h8; tick(); stw_en = 0; pwdata = '0;
    str_en = 1; #1;
    n_cmp++; if (prdata !== 32'h1) begin n_err++; $display("FAIL rx_clear got %h want 00000001", prdata); end
    tick(); str_en = 0;
  endtask

  task automatic test_irq();
    stw_en = 1; pwdata = 32'h100; tick(); stw_en = 0; pwdata = '0;
    rx_valid = 1; rx_data = 8'h7E; tick(); rx_valid = 0;
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_early got %b want 0", irq); end
    tick();
    n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL irq_rx got %b want 1", irq); end
    rx_en = 1; tick(); rx_en = 0;
    n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL irq_hold got %b want 1", irq); end
    tick();
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_rx_clr got %b want 0", irq); end
    stw_en = 1; pwdata = 32'h200; tick(); stw_en = 0; pwdata = '0;
    tick();
    n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL irq_txe got %b want 1", irq); end
    tx_busy = 1; str_en = 1; #1;
    n_cmp++; if (prdata !== 32'h221) begin n_err++; $display("FAIL busy_status got %h want 00000221", prdata); end
    tick(); str_en = 0; tick();
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_busy got %b want 0", irq); end
    tx_busy = 0;
    stw_en = 1; pwdata = 32'h0; tick(); stw_en = 0;
  endtask

  task automatic test_reset_mid();
    fill_fifo(8'h21);
    tx_en = 1; pwdata = 32'h77; tick(); tick();
    rst_n = 1'b0; #1;
    n_cmp++;
    if (pready !== 1'b1 || tx_valid !== 1'b0) begin
      n_err++; $display("FAIL rst_mid got rdy=%b v=%b want rdy=1 v=0", pready, tx_valid);
    end
    tick(); tx_en = 0; pwdata = '0; rst_n = 1'b1;
    tick();
    str_en = 1; #1;
    n_cmp++; if (prdata !== 32'h1) begin n_err++; $display("FAIL rst_mid_status got %h want 00000001", prdata); end
    tick(); str_en = 0;
  endtask

  initial begin
    test_reset();
    test_tx_fill();
    test_tx_wait();
    test_tx_drop();
    test_rx();
    test_irq();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
